mul_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit for the pipelined MIPS core. It sits in the EX stage beside the ALU.
- Executes MULT, MULTU, DIV and DIVU into private HI/LO registers, and services MTHI and MTLO.
- The hazard unit stalls any multiply/divide-class instruction in D while Start or Busy is high.

---
 rtl/mul_div_unit.sv | 147 ++++++++++++++
 tb/tb_mul_div_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with private HI/LO, plus MTHI/MTLO writes.
// Latency: MulCycles or DivCycles edges from accept to HI/LO update; MTHI/MTLO take one edge.
// Backpressure: Busy is high while an operation runs, and Start is ignored until it falls.
module mul_div_unit #(
  parameter int MulCycles = 5,
  parameter int DivCycles = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] In0,
  input  logic [31:0] In1,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam logic [3:0] MUL_CNT = 4'(MulCycles);
  localparam logic [3:0] DIV_CNT = 4'(DivCycles);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        latch_en;
  logic        start_md;

  logic [63:0] prod;
  logic        div_signed;
  logic [31:0] num, den, den_safe, q_mag, r_mag, quo, rem;
  logic [31:0] res_hi, res_lo;

  // Only multiply/divide requests start a RUN; MTHI/MTLO complete in IDLE.
  assign start_md = Start && (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);

  // Result from the latched operands; divide runs on magnitudes so the
  // 0x80000000 / -1 case needs no special handling.
  always_comb begin
    // Low 64 bits of a sign-extended product equal the signed product.
    if (op_q == OP_MULT) prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    else                 prod = {32'd0, a_q} * {32'd0, b_q};
    div_signed = (op_q == OP_DIV);
    num        = (div_signed && a_q[31]) ? 32'd0 - a_q : a_q;
    den        = (div_signed && b_q[31]) ? 32'd0 - b_q : b_q;
    den_safe   = (den == 32'd0) ? 32'd1 : den;
    q_mag      = num / den_safe;
    r_mag      = num % den_safe;
    quo        = (div_signed && (a_q[31] ^ b_q[31])) ? 32'd0 - q_mag : q_mag;
    rem        = (div_signed && a_q[31]) ? 32'd0 - r_mag : r_mag;
    if (op_q == OP_MULT || op_q == OP_MULTU) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (b_q == 32'd0) begin
      res_hi = a_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: accept a mul/div in IDLE, return to IDLE on the final count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_md) state_d = RUN;
      RUN:  if (cnt_q == 4'd1) state_d = IDLE;
    endcase
  end

  // Per-state actions: latch operands, count down, commit HI/LO once.
  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MULT, OP_MULTU: begin
              latch_en = 1'b1;
              cnt_d    = MUL_CNT;
            end
            OP_DIV, OP_DIVU: begin
              latch_en = 1'b1;
              cnt_d    = DIV_CNT;
            end
            OP_MTHI: hi_d = In0;
            OP_MTLO: lo_d = In0;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
    endcase
  end

  // Datapath registers: operand/op latches, counter, HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      cnt_q <= 4'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      if (latch_en) begin
        op_q <= MDOp;
        a_q  <= In0;
        b_q  <= In1;
      end
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign Busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: behavioural model plus directed literal checks.
// Latency: the model predicts Busy/HI/LO per cycle from the accept edge and the cycle counts.
// Backpressure: Start is only driven when Busy is low, except one deliberate in-RUN MTHI.
module tb_mul_div_unit;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] In0, In1;
  logic        Busy;
  logic [31:0] HI, LO;

  int tests;
  int fails;
  bit chk_en;

  mul_div_unit #(.MulCycles(MUL_N), .DivCycles(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .In0   (In0),
    .In1   (In1),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {HI,LO} computed with wide plain arithmetic.
  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'd0;
    case (op)
      4'd1: res = 64'(sa * sb);
      4'd2: res = {32'd0, a} * {32'd0, b};
      4'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      4'd4: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Model state: remaining busy cycles, pending result, architectural HI/LO.
  int          m_left;
  logic [63:0] m_pend;
  logic [31:0] m_hi, m_lo;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_pend <= 64'd0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (Start) begin
      if (MDOp == 4'd1 || MDOp == 4'd2) begin
        m_left <= MUL_N;
        m_pend <= ref_res(MDOp, In0, In1);
      end else if (MDOp == 4'd3 || MDOp == 4'd4) begin
        m_left <= DIV_N;
        m_pend <= ref_res(MDOp, In0, In1);
      end else if (MDOp == 4'd5) begin
        m_hi <= In0;
      end else if (MDOp == 4'd6) begin
        m_lo <= In0;
      end
    end
  end

  // Every-cycle comparison against the model, on the inactive edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_vs_model", {31'd0, Busy}, {31'd0, (m_left > 0)});
      check("hi_vs_model", HI, m_hi);
      check("lo_vs_model", LO, m_lo);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDOp  = op;
    In0   = a;
    In1   = b;
    step();
    Start = 1'b0;
    MDOp  = 4'd0;
  endtask

  // Issue, measure Busy length (bounded), then pin HI/LO to literals.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    logic [31:0] hi0, lo0;
    hi0 = HI;
    lo0 = LO;
    issue(op, a, b);
    n = 0;
    while (Busy && n < 40) begin
      if (n == 1) begin
        check({name, "_hi_hold"}, HI, hi0);
        check({name, "_lo_hold"}, LO, lo0);
      end
      n++;
      step();
    end
    check({name, "_busy_cycles"}, n, exp_cyc);
    check({name, "_hi"}, HI, exp_hi);
    check({name, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    int n;
    tests  = 0;
    fails  = 0;
    chk_en = 1'b0;
    clk    = 1'b0;
    reset  = 1'b0;
    Start  = 1'b0;
    MDOp   = 4'd0;
    In0    = 32'd0;
    In1    = 32'd0;
    step();
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b1;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    step();

    // Model self-pins on spec literals.
    check("model_div_ovf_lo", ref_res(4'd3, 32'h8000_0000, 32'hFFFF_FFFF) & 64'hFFFF_FFFF, 32'h8000_0000);
    check("model_divu_7_lo", ref_res(4'd4, 32'hFFFF_FFF9, 32'd2) & 64'hFFFF_FFFF, 32'h7FFF_FFFC);

    run_op("mult_m2x3",  4'd1, 32'hFFFF_FFFE, 32'd3, MUL_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max",  4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_N, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7_2",   4'd3, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_m7_2",  4'd4, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("divu_by0",   4'd4, 32'h0000_1234, 32'd0, DIV_N, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_ovf",    4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0000_0000, 32'h8000_0000);
    run_op("div_by0",    4'd3, 32'hFFFF_FF00, 32'd0, DIV_N, 32'hFFFF_FF00, 32'hFFFF_FFFF);

    // MTHI / MTLO in idle.
    issue(4'd5, 32'hAAAA_5555, 32'd0);
    check("mthi_hi", HI, 32'hAAAA_5555);
    check("mthi_busy", {31'd0, Busy}, 32'd0);
    issue(4'd6, 32'h0F0F_0F0F, 32'd0);
    check("mtlo_lo", LO, 32'h0F0F_0F0F);
    check("mtlo_hi_kept", HI, 32'hAAAA_5555);
    check("mtlo_busy", {31'd0, Busy}, 32'd0);

    // MTHI during a DIV run must be ignored: 100 / 7 -> q 14, r 2.
    issue(4'd3, 32'd100, 32'd7);
    step();
    issue(4'd5, 32'd1, 32'd0);
    check("mthi_in_run_ignored", HI, 32'hAAAA_5555);
    n = 0;
    while (Busy && n < 40) begin
      n++;
      step();
    end
    check("div_run_busy_cycles", n, DIV_N - 2);
    check("div_run_hi", HI, 32'd2);
    check("div_run_lo", LO, 32'd14);

    // Asynchronous reset in the 3rd cycle of a MULT.
    issue(4'd1, 32'd9, 32'd9);
    step();
    step();
    check("pre_reset_busy", {31'd0, Busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_reset_busy", {31'd0, Busy}, 32'd0);
    check("async_reset_hi", HI, 32'd0);
    check("async_reset_lo", LO, 32'd0);
    step();
    reset = 1'b1;
    step();

    // New MULT, then DIVU issued the cycle right after Busy falls.
    run_op("mult_6x7",   4'd1, 32'd6, 32'd7, MUL_N, 32'd0, 32'd42);
    run_op("divu_b2b",   4'd4, 32'd100, 32'd3, DIV_N, 32'd1, 32'd33);
    run_op("multu_b2b",  4'd2, 32'h0001_0000, 32'h0001_0000, MUL_N, 32'd1, 32'd0);

    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
